// File: rtl/pll_mgmt_if.sv
// PLL management bus (Avalon-MM style) between a reconfiguration master
// and the responder.
//   address     6-bit word address
//   write/read  single-cycle request pulses from the master
//   writedata   32-bit write data
//   readdata    32-bit registered read data
//   readvalid   one-cycle pulse, readdata valid in that cycle
//   waitrequest high = responder ignores requests this cycle
interface pll_mgmt_if;
    logic [5:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readvalid;
    logic        waitrequest;

    modport master (
        output address, write, read, writedata,
        input  readdata, readvalid, waitrequest
    );

    modport slave (
        input  address, write, read, writedata,
        output readdata, readvalid, waitrequest
    );
endinterface

// File: rtl/pll_mgmt_responder.sv
// Responder side of the PLL reconfiguration management bus. Holds the
// requested settings in shadow registers and, on a start write, runs an
// apply/relock sequence that publishes them on cfg_* with a cfg_valid
// strobe while emulating loss and recovery of PLL lock.
//
// Ports
//   CLK_50M, RESET   clock, synchronous active-high reset
//   mgmt             management bus, slave side
//   locked           emulated PLL lock
//   cfg_valid        one-cycle strobe, cfg_* stable until the next strobe
//   cfg_n/m/c0       18-bit counter words
//   cfg_k            32-bit fractional K word
//   cfg_bw, cfg_cp   bandwidth and charge-pump settings
//   err_drop         sticky, a request arrived while waitrequest was high
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | locked, requests accepted
// ST_WSETTLE | waitrequest high after a register write
// ST_APPLY   | busy applying new settings, locked low
// ST_RELOCK  | settings published, waiting for lock, requests accepted
module pll_mgmt_responder #(
    parameter int WR_WAIT      = 2,
    parameter int APPLY_CYCLES = 16,
    parameter int LOCK_CYCLES  = 64
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    pll_mgmt_if.slave   mgmt,
    output logic        locked,
    output logic        cfg_valid,
    output logic [17:0] cfg_n,
    output logic [17:0] cfg_m,
    output logic [17:0] cfg_c0,
    output logic [31:0] cfg_k,
    output logic [3:0]  cfg_bw,
    output logic [2:0]  cfg_cp,
    output logic        err_drop
);

    localparam int SEQ_MAX = (APPLY_CYCLES > LOCK_CYCLES) ? APPLY_CYCLES : LOCK_CYCLES;
    localparam int WW      = (WR_WAIT > 0) ? $clog2(WR_WAIT + 1) : 1;
    localparam int SW      = (SEQ_MAX > 0) ? $clog2(SEQ_MAX + 1) : 1;

    localparam logic [WW-1:0] WAIT_LOAD  = WW'(WR_WAIT);
    localparam logic [SW-1:0] APPLY_LOAD = SW'(APPLY_CYCLES);
    localparam logic [SW-1:0] LOCK_LOAD  = SW'(LOCK_CYCLES);

    localparam logic [5:0] A_MODE   = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_START  = 6'd2;
    localparam logic [5:0] A_N      = 6'd3;
    localparam logic [5:0] A_M      = 6'd4;
    localparam logic [5:0] A_C      = 6'd5;
    localparam logic [5:0] A_K      = 6'd7;
    localparam logic [5:0] A_BW     = 6'd8;
    localparam logic [5:0] A_CP     = 6'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WSETTLE,
        ST_APPLY,
        ST_RELOCK
    } state_t;

    state_t      state_q, state_nx;
    logic [WW-1:0] wcnt_q, wcnt_nx;
    logic [SW-1:0] seq_cnt_q, seq_cnt_nx;
    logic        locked_nx;
    logic        waitreq_nx;
    logic        go_apply;
    logic        finish_apply;

    // shadow registers
    logic        mode_q;
    logic [17:0] n_q;
    logic [17:0] m_q;
    logic [17:0] c0_q;
    logic [31:0] k_q;
    logic [3:0]  bw_q;
    logic [2:0]  cp_q;

    logic        wr_acc;
    logic        rd_acc;
    logic        start_wr;
    logic        shadow_wr;
    logic        mode_nx;
    logic        busy;
    logic [31:0] rd_val;

    // A write wins over a simultaneous read; the read is silently dropped.
    assign wr_acc    = mgmt.write & ~mgmt.waitrequest;
    assign rd_acc    = mgmt.read & ~mgmt.write & ~mgmt.waitrequest;
    assign start_wr  = wr_acc & (mgmt.address == A_START);
    assign shadow_wr = wr_acc & ~start_wr;
    assign busy      = (state_q == ST_APPLY);
    assign mode_nx   = (shadow_wr && mgmt.address == A_MODE) ? mgmt.writedata[0] : mode_q;

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            mode_q <= 1'b0;
            n_q    <= 18'h10000;
            m_q    <= '0;
            c0_q   <= '0;
            k_q    <= 32'd1;
            bw_q   <= 4'd7;
            cp_q   <= 3'd1;
        end else if (shadow_wr) begin
            case (mgmt.address)
                A_MODE: mode_q <= mgmt.writedata[0];
                A_N:    n_q    <= mgmt.writedata[17:0];
                A_M:    m_q    <= mgmt.writedata[17:0];
                // only counter select 0 maps to C0; other selects are discarded
                A_C:    if (mgmt.writedata[22:18] == 5'd0) c0_q <= mgmt.writedata[17:0];
                A_K:    k_q    <= mgmt.writedata;
                A_BW:   bw_q   <= mgmt.writedata[3:0];
                A_CP:   cp_q   <= mgmt.writedata[2:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (mgmt.address)
            A_MODE:   rd_val[0]    = mode_q;
            A_STATUS: rd_val[0]    = busy;
            A_N:      rd_val[17:0] = n_q;
            A_M:      rd_val[17:0] = m_q;
            A_C:      rd_val[17:0] = c0_q;
            A_K:      rd_val       = k_q;
            A_BW:     rd_val[3:0]  = bw_q;
            A_CP:     rd_val[2:0]  = cp_q;
            default: ;
        endcase
    end

    always_comb begin
        state_nx     = state_q;
        seq_cnt_nx   = seq_cnt_q;
        locked_nx    = locked;
        go_apply     = 1'b0;
        finish_apply = 1'b0;
        wcnt_nx      = (wcnt_q != '0) ? wcnt_q - WW'(1) : '0;

        // Writes accepted while polling during APPLY do not stall the bus.
        if (shadow_wr && state_q != ST_APPLY) begin
            wcnt_nx = WAIT_LOAD;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_wr) begin
                    go_apply = 1'b1;
                end else if (wcnt_nx != '0) begin
                    state_nx = ST_WSETTLE;
                end
            end
            ST_WSETTLE: begin
                if (wcnt_nx == '0) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_APPLY: begin
                // a start write accepted in polling mode is ignored here
                if (seq_cnt_q <= SW'(1)) begin
                    finish_apply = 1'b1;
                end else begin
                    seq_cnt_nx = seq_cnt_q - SW'(1);
                end
            end
            ST_RELOCK: begin
                if (start_wr) begin
                    go_apply = 1'b1;
                end else if (seq_cnt_q <= SW'(1)) begin
                    locked_nx = 1'b1;
                    state_nx  = (wcnt_nx != '0) ? ST_WSETTLE : ST_IDLE;
                end else begin
                    seq_cnt_nx = seq_cnt_q - SW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // A zero-length phase collapses into the following one.
        if (go_apply) begin
            locked_nx = 1'b0;
            if (APPLY_CYCLES == 0) begin
                finish_apply = 1'b1;
            end else begin
                state_nx   = ST_APPLY;
                seq_cnt_nx = APPLY_LOAD;
            end
        end

        if (finish_apply) begin
            if (LOCK_CYCLES == 0) begin
                locked_nx = 1'b1;
                state_nx  = (wcnt_nx != '0) ? ST_WSETTLE : ST_IDLE;
            end else begin
                locked_nx  = 1'b0;
                state_nx   = ST_RELOCK;
                seq_cnt_nx = LOCK_LOAD;
            end
        end

        waitreq_nx = (wcnt_nx != '0) || (state_nx == ST_APPLY && !mode_nx);
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q          <= ST_IDLE;
            wcnt_q           <= '0;
            seq_cnt_q        <= '0;
            locked           <= 1'b1;
            mgmt.waitrequest <= 1'b0;
            mgmt.readvalid   <= 1'b0;
            mgmt.readdata    <= '0;
            err_drop         <= 1'b0;
            cfg_valid        <= 1'b0;
            cfg_n            <= '0;
            cfg_m            <= '0;
            cfg_c0           <= '0;
            cfg_k            <= '0;
            cfg_bw           <= '0;
            cfg_cp           <= '0;
        end else begin
            state_q          <= state_nx;
            wcnt_q           <= wcnt_nx;
            seq_cnt_q        <= seq_cnt_nx;
            locked           <= locked_nx;
            mgmt.waitrequest <= waitreq_nx;
            mgmt.readvalid   <= rd_acc;
            if (rd_acc) begin
                mgmt.readdata <= rd_val;
            end
            if ((mgmt.write || mgmt.read) && mgmt.waitrequest) begin
                err_drop <= 1'b1;
            end
            cfg_valid <= finish_apply;
            if (finish_apply) begin
                cfg_n  <= n_q;
                cfg_m  <= m_q;
                cfg_c0 <= c0_q;
                cfg_k  <= k_q;
                cfg_bw <= bw_q;
                cfg_cp <= cp_q;
            end
        end
    end

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Self-checking bench for pll_mgmt_responder: directed scenarios plus a
// randomized run compared against a cycle-stamped behavioural model.
module tb_pll_mgmt_responder;

    localparam int WR_WAIT      = 2;
    localparam int APPLY_CYCLES = 16;
    localparam int LOCK_CYCLES  = 64;

    logic        CLK_50M = 1'b0;
    logic        RESET;
    logic        locked;
    logic        cfg_valid;
    logic [17:0] cfg_n;
    logic [17:0] cfg_m;
    logic [17:0] cfg_c0;
    logic [31:0] cfg_k;
    logic [3:0]  cfg_bw;
    logic [2:0]  cfg_cp;
    logic        err_drop;

    pll_mgmt_if bus ();

    pll_mgmt_responder #(
        .WR_WAIT      (WR_WAIT),
        .APPLY_CYCLES (APPLY_CYCLES),
        .LOCK_CYCLES  (LOCK_CYCLES)
    ) dut (
        .CLK_50M   (CLK_50M),
        .RESET     (RESET),
        .mgmt      (bus),
        .locked    (locked),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_m     (cfg_m),
        .cfg_c0    (cfg_c0),
        .cfg_k     (cfg_k),
        .cfg_bw    (cfg_bw),
        .cfg_cp    (cfg_cp),
        .err_drop  (err_drop)
    );

    always #10 CLK_50M = ~CLK_50M;

    int checks = 0;
    int errors = 0;

    // Behavioural model: events are stamped with absolute cycle numbers.
    int          cyc;
    logic        m_mode;
    logic [17:0] m_n, m_m, m_c0;
    logic [31:0] m_k;
    logic [3:0]  m_bw;
    logic [2:0]  m_cp;
    bit          seq_active;
    int          apply_start, cfg_cyc, lock_cyc, wr_free;

    logic        e_waitreq, e_locked, e_cfg_valid, e_err, e_readvalid;
    logic [31:0] e_readdata;
    logic [17:0] e_cfg_n, e_cfg_m, e_cfg_c0;
    logic [31:0] e_cfg_k;
    logic [3:0]  e_cfg_bw;
    logic [2:0]  e_cfg_cp;

    function automatic bit in_apply_at(int c);
        return seq_active && c >= apply_start && c < cfg_cyc;
    endfunction

    function automatic logic [31:0] reg_value(logic [5:0] a, bit bsy);
        case (a)
            6'd0: return {31'd0, m_mode};
            6'd1: return {31'd0, bsy};
            6'd3: return {14'd0, m_n};
            6'd4: return {14'd0, m_m};
            6'd5: return {14'd0, m_c0};
            6'd7: return m_k;
            6'd8: return {28'd0, m_bw};
            6'd9: return {29'd0, m_cp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_outputs();
        e_waitreq   = (cyc < wr_free) || (in_apply_at(cyc) && !m_mode);
        e_locked    = !(seq_active && cyc >= apply_start && cyc < lock_cyc);
        e_cfg_valid = seq_active && cyc == cfg_cyc;
    endtask

    task automatic model_reset();
        m_mode = 1'b0; m_n = 18'h10000; m_m = '0; m_c0 = '0;
        m_k = 32'd1; m_bw = 4'd7; m_cp = 3'd1;
        seq_active = 1'b0; apply_start = 0; cfg_cyc = 0; lock_cyc = 0; wr_free = 0;
        e_err = 1'b0; e_readvalid = 1'b0; e_readdata = '0;
        e_cfg_n = '0; e_cfg_m = '0; e_cfg_c0 = '0; e_cfg_k = '0; e_cfg_bw = '0; e_cfg_cp = '0;
    endtask

    task automatic model_advance(bit rst, bit wr, bit rd, logic [5:0] addr, logic [31:0] data);
        bit ia;
        bit rv;
        ia = in_apply_at(cyc);
        rv = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (seq_active && cyc + 1 == cfg_cyc) begin
                e_cfg_n = m_n; e_cfg_m = m_m; e_cfg_c0 = m_c0;
                e_cfg_k = m_k; e_cfg_bw = m_bw; e_cfg_cp = m_cp;
            end
            if ((wr || rd) && e_waitreq) begin
                e_err = 1'b1;
            end else if (wr) begin
                if (addr == 6'd2) begin
                    if (!ia) begin
                        seq_active  = 1'b1;
                        apply_start = cyc + 1;
                        cfg_cyc     = apply_start + APPLY_CYCLES;
                        lock_cyc    = cfg_cyc + LOCK_CYCLES;
                    end
                end else begin
                    case (addr)
                        6'd0: m_mode = data[0];
                        6'd3: m_n    = data[17:0];
                        6'd4: m_m    = data[17:0];
                        6'd5: if (data[22:18] == 5'd0) m_c0 = data[17:0];
                        6'd7: m_k    = data;
                        6'd8: m_bw   = data[3:0];
                        6'd9: m_cp   = data[2:0];
                        default: ;
                    endcase
                    if (!ia) wr_free = cyc + 1 + WR_WAIT;
                end
            end else if (rd) begin
                rv = 1'b1;
                e_readdata = reg_value(addr, ia);
            end
            e_readvalid = rv;
        end
        cyc = cyc + 1;
        model_outputs();
    endtask

    // Drive one cycle of stimulus, advance the model, land on the next negedge.
    task automatic step(bit rst, bit wr, bit rd, logic [5:0] addr, logic [31:0] data);
        RESET         = rst;
        bus.write     = wr;
        bus.read      = rd;
        bus.address   = addr;
        bus.writedata = data;
        model_advance(rst, wr, rd, addr, data);
        @(posedge CLK_50M);
        @(negedge CLK_50M);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
        idle();
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (bus.waitrequest && n < 100) begin
            idle();
            n++;
        end
        ok = !bus.waitrequest;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reset_locked got %0b exp 1", locked); end
        checks++; if (bus.waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %0b exp 0", bus.waitrequest); end
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid got %0b exp 0", cfg_valid); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err_drop); end
        checks++;
        if ({cfg_n, cfg_m, cfg_c0, cfg_k, cfg_bw, cfg_cp} !== '0) begin
            errors++; $display("FAIL reset_cfg got n=%0h m=%0h c0=%0h k=%0h exp 0", cfg_n, cfg_m, cfg_c0, cfg_k);
        end
        step(1'b0, 1'b0, 1'b1, 6'd1, 32'd0);
        checks++;
        if (bus.readvalid !== 1'b1 || bus.readdata !== 32'd0) begin
            errors++; $display("FAIL reset_status got rv=%0b data=%0h exp rv=1 data=0", bus.readvalid, bus.readdata);
        end
        step(1'b0, 1'b0, 1'b1, 6'd3, 32'd0);
        checks++;
        if (bus.readdata !== 32'h10000) begin
            errors++; $display("FAIL reset_shadow_n got %0h exp 10000", bus.readdata);
        end
    endtask

    task automatic test_full_sequence();
        logic [5:0]  addrs [7] = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8};
        logic [31:0] datas [7] = '{32'd0, 32'h20302, 32'd1, 32'h10000, 32'h00202, 32'd1, 32'd7};
        bit ok;
        int n;
        int pulses;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wait_ready(ok);
            checks++; if (!ok) begin errors++; $display("FAIL seq_ready timeout at write %0d", i); end
            step(1'b0, 1'b1, 1'b0, addrs[i], datas[i]);
            n = 0;
            while (bus.waitrequest && n < 10) begin idle(); n++; end
            checks++; if (n !== WR_WAIT) begin errors++; $display("FAIL seq_wait_len write %0d got %0d exp %0d", i, n, WR_WAIT); end
        end
        step(1'b0, 1'b1, 1'b0, 6'd2, 32'hdead);
        checks++;
        if (locked !== 1'b0 || bus.waitrequest !== 1'b1) begin
            errors++; $display("FAIL seq_apply_entry got locked=%0b wr=%0b exp locked=0 wr=1", locked, bus.waitrequest);
        end
        n = 1;
        while (!cfg_valid && n < 60) begin idle(); n++; end
        checks++; if (n !== APPLY_CYCLES + 1) begin errors++; $display("FAIL seq_cfg_latency got %0d exp %0d", n, APPLY_CYCLES + 1); end
        checks++; if (cfg_m !== 18'h20302) begin errors++; $display("FAIL seq_cfg_m got %0h exp 20302", cfg_m); end
        checks++; if (cfg_k !== 32'd1) begin errors++; $display("FAIL seq_cfg_k got %0h exp 1", cfg_k); end
        checks++; if (cfg_c0 !== 18'h00202) begin errors++; $display("FAIL seq_cfg_c0 got %0h exp 202", cfg_c0); end
        checks++; if (cfg_n !== 18'h10000) begin errors++; $display("FAIL seq_cfg_n got %0h exp 10000", cfg_n); end
        checks++; if (cfg_bw !== 4'd7 || cfg_cp !== 3'd1) begin errors++; $display("FAIL seq_cfg_bw_cp got %0h/%0h exp 7/1", cfg_bw, cfg_cp); end
        n = 0;
        pulses = 0;
        while (!locked && n < 150) begin idle(); n++; if (cfg_valid) pulses++; end
        checks++; if (n !== LOCK_CYCLES) begin errors++; $display("FAIL seq_lock_latency got %0d exp %0d", n, LOCK_CYCLES); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL seq_extra_cfg_valid got %0d exp 0", pulses); end
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 6'd4, 32'h00111);
        step(1'b0, 1'b1, 1'b0, 6'd4, 32'h00222);
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err got %0b exp 1", err_drop); end
        wait_ready(ok);
        step(1'b0, 1'b0, 1'b1, 6'd4, 32'd0);
        checks++;
        if (bus.readvalid !== 1'b1 || bus.readdata !== 32'h111) begin
            errors++; $display("FAIL drop_shadow got rv=%0b data=%0h exp rv=1 data=111", bus.readvalid, bus.readdata);
        end
        // a write colliding with a read must not set anything extra
        step(1'b0, 1'b1, 1'b1, 6'd9, 32'd3);
        for (int i = 0; i < 20; i++) idle();
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got %0b exp 1", err_drop); end
        checks++; if (bus.readvalid !== 1'b0) begin errors++; $display("FAIL drop_rv_quiet got %0b exp 0", bus.readvalid); end
    endtask

    task automatic test_polling();
        bit ok;
        int pulses;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 6'd0, 32'd1);
        wait_ready(ok);
        step(1'b0, 1'b1, 1'b0, 6'd2, 32'd0);
        for (int i = 0; i < 4; i++) idle();
        step(1'b0, 1'b0, 1'b1, 6'd1, 32'd0);
        checks++;
        if (bus.readvalid !== 1'b1 || bus.readdata !== 32'd1) begin
            errors++; $display("FAIL poll_status got rv=%0b data=%0h exp rv=1 data=1", bus.readvalid, bus.readdata);
        end
        checks++; if (bus.waitrequest !== 1'b0) begin errors++; $display("FAIL poll_waitreq got %0b exp 0", bus.waitrequest); end
        idle();
        step(1'b0, 1'b1, 1'b0, 6'd2, 32'd0);
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            idle();
            if (cfg_valid) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL poll_cfg_pulses got %0d exp 1", pulses); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL poll_err got %0b exp 0", err_drop); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL poll_locked got %0b exp 1", locked); end
    endtask

    task automatic run_apply(output bit seen);
        bit ok;
        int n;
        wait_ready(ok);
        step(1'b0, 1'b1, 1'b0, 6'd2, 32'd0);
        n = 0;
        while (!cfg_valid && n < 40) begin idle(); n++; end
        seen = cfg_valid;
        n = 0;
        while (!locked && n < 100) begin idle(); n++; end
    endtask

    task automatic test_c_select();
        bit ok;
        bit seen;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 6'd5, 32'h00040123);
        run_apply(seen);
        checks++; if (!seen) begin errors++; $display("FAIL csel_cfg_valid timeout"); end
        checks++; if (cfg_c0 !== 18'd0) begin errors++; $display("FAIL csel_ignored got %0h exp 0", cfg_c0); end
        wait_ready(ok);
        step(1'b0, 1'b1, 1'b0, 6'd5, 32'h00000456);
        run_apply(seen);
        checks++; if (cfg_c0 !== 18'h456) begin errors++; $display("FAIL csel_taken got %0h exp 456", cfg_c0); end
    endtask

    task automatic test_reset_mid_apply();
        bit ok;
        int pulses;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 6'd4, 32'h01234);
        wait_ready(ok);
        step(1'b0, 1'b1, 1'b0, 6'd2, 32'd0);
        for (int i = 0; i < 7; i++) idle();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (cfg_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_cfg_valid got %0d exp 0", pulses); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL midrst_locked got %0b exp 1", locked); end
        checks++;
        if ({cfg_n, cfg_m, cfg_c0, cfg_k, cfg_bw, cfg_cp} !== '0) begin
            errors++; $display("FAIL midrst_cfg got n=%0h m=%0h k=%0h exp 0", cfg_n, cfg_m, cfg_k);
        end
    endtask

    task automatic test_random();
        logic [5:0] addr_tab [12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd63};
        bit rst, wr, rd;
        logic [5:0]  addr;
        logic [31:0] data;
        int r;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 799) == 0);
            r    = $urandom_range(0, 99);
            wr   = (r < 22);
            rd   = (r >= 18 && r < 40);
            addr = addr_tab[$urandom_range(0, 11)];
            if (addr == 6'd2 && $urandom_range(0, 3) != 0) addr = 6'd4;
            data = $urandom();
            if ($urandom_range(0, 1) == 1) data[22:18] = 5'd0;
            step(rst, wr, rd, addr, data);
            checks++; if (bus.waitrequest !== e_waitreq) begin errors++; $display("FAIL rnd_waitreq cyc %0d got %0b exp %0b", cyc, bus.waitrequest, e_waitreq); end
            checks++; if (locked !== e_locked) begin errors++; $display("FAIL rnd_locked cyc %0d got %0b exp %0b", cyc, locked, e_locked); end
            checks++; if (cfg_valid !== e_cfg_valid) begin errors++; $display("FAIL rnd_cfg_valid cyc %0d got %0b exp %0b", cyc, cfg_valid, e_cfg_valid); end
            checks++; if (err_drop !== e_err) begin errors++; $display("FAIL rnd_err cyc %0d got %0b exp %0b", cyc, err_drop, e_err); end
            checks++; if (bus.readvalid !== e_readvalid) begin errors++; $display("FAIL rnd_readvalid cyc %0d got %0b exp %0b", cyc, bus.readvalid, e_readvalid); end
            if (e_readvalid) begin
                checks++; if (bus.readdata !== e_readdata) begin errors++; $display("FAIL rnd_readdata cyc %0d got %0h exp %0h", cyc, bus.readdata, e_readdata); end
            end
            checks++;
            if ({cfg_n, cfg_m, cfg_c0, cfg_k, cfg_bw, cfg_cp} !== {e_cfg_n, e_cfg_m, e_cfg_c0, e_cfg_k, e_cfg_bw, e_cfg_cp}) begin
                errors++;
                $display("FAIL rnd_cfg cyc %0d got n=%0h m=%0h c0=%0h k=%0h bw=%0h cp=%0h exp n=%0h m=%0h c0=%0h k=%0h bw=%0h cp=%0h",
                         cyc, cfg_n, cfg_m, cfg_c0, cfg_k, cfg_bw, cfg_cp,
                         e_cfg_n, e_cfg_m, e_cfg_c0, e_cfg_k, e_cfg_bw, e_cfg_cp);
            end
        end
    endtask

    initial begin
        RESET         = 1'b1;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        cyc = 0;
        model_reset();
        model_outputs();
        @(negedge CLK_50M);
        test_reset();
        test_full_sequence();
        test_drop();
        test_polling();
        test_c_select();
        test_reset_mid_apply();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
